// File: rtl/cpu_pkg.sv
// Definitions shared by the program loader and the CPU control block:
// loader states, controller stage numbering and the data path / RAM sizes.
package cpu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int RAM_DEPTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SYNC,
    ST_STREAM,
    ST_DONE
  } loader_state_e;

  // One instruction slot has six controller stages, T0 through T5.
  typedef enum logic [2:0] {
    T0,
    T1,
    T2,
    T3,
    T4,
    T5
  } stage_e;

endpackage

// File: rtl/prog_buffer.sv
// Program image store: register array with write/read pointers, a count of
// buffered bytes, and a registered head byte that always shows mem[rp].
module prog_buffer #(
  parameter int PROG_LEN = 16,
  parameter int DATA_W   = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        clear_i,
  input  logic                        wr_en_i,
  input  logic [DATA_W-1:0]           wr_data_i,
  input  logic                        rd_adv_i,
  output logic [DATA_W-1:0]           head_o,
  output logic [$clog2(PROG_LEN):0]   fill_level_o
);

  localparam int AW = $clog2(PROG_LEN);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [PROG_LEN];
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic [DATA_W-1:0] head_q, head_d;

  // The head byte is fetched from the next read pointer, with a bypass so a
  // byte written this cycle at that address is seen immediately.
  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    fill_d = fill_q;
    if (clear_i) begin
      wp_d   = '0;
      rp_d   = '0;
      fill_d = '0;
    end else begin
      if (wr_en_i) begin
        wp_d   = wp_q + AW'(1);
        fill_d = fill_q + CW'(1);
      end
      if (rd_adv_i) begin
        rp_d = rp_q + AW'(1);
      end
    end
    head_d = (wr_en_i && (wp_q == rp_d)) ? wr_data_i : mem_q[rp_d];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fill_q <= '0;
      head_q <= '0;
      for (int i = 0; i < PROG_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      fill_q <= fill_d;
      head_q <= head_d;
      if (wr_en_i) begin
        mem_q[wp_q] <= wr_data_i;
      end
    end
  end

  assign head_o       = head_q;
  assign fill_level_o = fill_q;

endmodule

// File: rtl/program_loader.sv
// Buffers a whole program image from the pins, then feeds it to the CPU one byte
// per instruction slot. Define LOADER_CHECKSUM_EN to require a trailing checksum byte.
module program_loader
  import cpu_pkg::*;
#(
  parameter int PROG_LEN = RAM_DEPTH,
  parameter int DATA_W   = DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        load_en,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        ready,
  input  logic                        read_ui_in,
  input  logic                        done_load,
  output logic                        programming,
  output logic [DATA_W-1:0]           prog_data,
  output logic [$clog2(PROG_LEN):0]   byte_count,
`ifdef LOADER_CHECKSUM_EN
  output logic                        cksum_err,
`endif
  output logic                        load_complete,
  output logic [$clog2(PROG_LEN):0]   fill_level
);

  localparam int AW = $clog2(PROG_LEN);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(PROG_LEN);
  localparam logic [CW-1:0] LAST = CW'(PROG_LEN - 1);

  loader_state_e state_q, state_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic          programming_q, programming_d;
  logic          load_complete_q, load_complete_d;
  logic          buf_clear, buf_wr, buf_adv, accept;
  logic [CW-1:0] buf_fill;
  logic          unused_read_ui_in;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d, sum_next;
  logic              cksum_err_q, cksum_err_d;
`endif

  assign unused_read_ui_in = read_ui_in;
  assign in_ready          = (state_q == ST_FILL);
  assign accept            = in_valid & in_ready;

  prog_buffer #(
    .PROG_LEN (PROG_LEN),
    .DATA_W   (DATA_W)
  ) u_buf (
    .clk          (clk),
    .resetn       (resetn),
    .clear_i      (buf_clear),
    .wr_en_i      (buf_wr),
    .wr_data_i    (in_data),
    .rd_adv_i     (buf_adv),
    .head_o       (prog_data),
    .fill_level_o (buf_fill)
  );

  // In STREAM a done_load is applied before ready is judged, so the release
  // to DONE sees the updated byte count and always lands on a T0 pulse.
  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    programming_d   = programming_q;
    load_complete_d = load_complete_q;
    buf_clear       = 1'b0;
    buf_wr          = 1'b0;
    buf_adv         = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d           = sum_q;
    cksum_err_d     = cksum_err_q;
    sum_next        = sum_q + in_data;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          buf_clear       = 1'b1;
          byte_cnt_d      = '0;
          load_complete_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d           = '0;
          cksum_err_d     = 1'b0;
`endif
          state_d         = ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          if (buf_fill != FULL) begin
            buf_wr = 1'b1;
            sum_d  = sum_next;
          end else if (sum_next != '0) begin
            cksum_err_d     = 1'b1;
            load_complete_d = 1'b1;
            state_d         = ST_DONE;
          end else begin
            state_d = ST_SYNC;
          end
`else
          buf_wr = 1'b1;
          if (buf_fill == LAST) begin
            state_d = ST_SYNC;
          end
`endif
        end
      end
      ST_SYNC: begin
        if (ready) begin
          programming_d = 1'b1;
          state_d       = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (done_load && (byte_cnt_q != FULL)) begin
          byte_cnt_d = byte_cnt_q + CW'(1);
          buf_adv    = 1'b1;
        end
        if (ready && (byte_cnt_d == FULL)) begin
          programming_d   = 1'b0;
          load_complete_d = 1'b1;
          state_d         = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!load_en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      byte_cnt_q      <= '0;
      programming_q   <= 1'b0;
      load_complete_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q           <= '0;
      cksum_err_q     <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      byte_cnt_q      <= byte_cnt_d;
      programming_q   <= programming_d;
      load_complete_q <= load_complete_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q           <= sum_d;
      cksum_err_q     <= cksum_err_d;
`endif
    end
  end

  assign programming   = programming_q;
  assign byte_count    = byte_cnt_q;
  assign load_complete = load_complete_q;
  assign fill_level    = buf_fill;
`ifdef LOADER_CHECKSUM_EN
  assign cksum_err     = cksum_err_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: models the controller slot pulses and a
// small RAM, and checks fill, streaming alignment, release and reset behaviour.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       resetn, load_en, in_valid, in_ready;
  logic [7:0] in_data, prog_data;
  logic       ready, read_ui_in, done_load, programming, load_complete;
  logic [4:0] byte_count, fill_level;
`ifdef LOADER_CHECKSUM_EN
  logic       cksum_err;
`endif

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] ram [16];
  int         ram_addr = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk           (clk),
    .resetn        (resetn),
    .load_en       (load_en),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ready         (ready),
    .read_ui_in    (read_ui_in),
    .done_load     (done_load),
    .programming   (programming),
    .prog_data     (prog_data),
    .byte_count    (byte_count),
`ifdef LOADER_CHECKSUM_EN
    .cksum_err     (cksum_err),
`endif
    .load_complete (load_complete),
    .fill_level    (fill_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_data    = 8'h00;
    ready      = 1'b0;
    read_ui_in = 1'b0;
    done_load  = 1'b0;
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    load_en = 1'b0;
    idle_inputs();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic start_load();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  // Pushes base..base+15 with in_valid toggling; appends a matching checksum
  // byte when the checksum build is selected.
  task automatic push_image(input logic [7:0] base);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] s = 8'h00;
`endif
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
`ifdef LOADER_CHECKSUM_EN
      s = s + in_data;
`endif
      tick();
      in_valid = 1'b0;
      in_data  = 8'hEE;
      tick();
    end
`ifdef LOADER_CHECKSUM_EN
    in_valid = 1'b1;
    in_data  = 8'h00 - s;
    tick();
    in_valid = 1'b0;
    tick();
`endif
  endtask

  // Controller model for one slot from stage 'first' to T5; the RAM captures
  // prog_data in the T3 window and the address advances on the T4 pulse.
  task automatic run_slot(input int first);
    for (int s = first; s < 6; s++) begin
      ready      = (s == 0);
      read_ui_in = (s == 3);
      done_load  = (s == 4);
      if (s == 3 && programming === 1'b1 && ram_addr < 16) ram[ram_addr] = prog_data;
      if (s == 4 && programming === 1'b1) ram_addr++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run += 6;
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    if (programming !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_programming: got %b expected 0", programming); end
    if (prog_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_prog_data: got %h expected 00", prog_data); end
    if (byte_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_byte_count: got %0d expected 0", byte_count); end
    if (load_complete !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_load_complete: got %b expected 0", load_complete); end
    if (fill_level !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_fill_level: got %0d expected 0", fill_level); end
  endtask

  task automatic test_fill_backpressure();
    start_load();
    tests_run += 2;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_in_ready: got %b expected 1", in_ready); end
    done_load = 1'b1;
    ready     = 1'b1;
    tick();
    idle_inputs();
    if (byte_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL fill_spurious_done: got %0d expected 0", byte_count); end
    push_image(8'h40);
    tests_run += 3;
    if (fill_level !== 5'd16) begin tests_failed++; $display("[TB] FAIL fill_level_full: got %0d expected 16", fill_level); end
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_in_ready_drop: got %b expected 0", in_ready); end
    if (programming !== 1'b0) begin tests_failed++; $display("[TB] FAIL sync_programming: got %b expected 0", programming); end
    in_valid = 1'b1;
    in_data  = 8'h99;
    tick();
    tick();
    idle_inputs();
    tests_run += 2;
    if (fill_level !== 5'd16) begin tests_failed++; $display("[TB] FAIL fill_17th_byte: got %0d expected 16", fill_level); end
    if (prog_data !== 8'h40) begin tests_failed++; $display("[TB] FAIL sync_prog_data: got %h expected 40", prog_data); end
    read_ui_in = 1'b1;
    tick();
    idle_inputs();
    tests_run += 3;
    if (byte_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL sync_read_ui_in_count: got %0d expected 0", byte_count); end
    if (prog_data !== 8'h40) begin tests_failed++; $display("[TB] FAIL sync_read_ui_in_data: got %h expected 40", prog_data); end
    if (programming !== 1'b0) begin tests_failed++; $display("[TB] FAIL sync_read_ui_in_prog: got %b expected 0", programming); end
  endtask

  task automatic test_alignment_release();
    ram_addr = 0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tests_run += 1;
    if (programming !== 1'b1) begin tests_failed++; $display("[TB] FAIL align_prog_rise: got %b expected 1", programming); end
    run_slot(1);
    for (int k = 1; k < 16; k++) run_slot(0);
    tests_run += 2;
    if (byte_count !== 5'd16) begin tests_failed++; $display("[TB] FAIL align_byte_count: got %0d expected 16", byte_count); end
    if (programming !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_hold: got %b expected 1", programming); end
    for (int a = 0; a < 16; a++) begin
      tests_run++;
      if (ram[a] !== 8'h40 + 8'(a)) begin
        tests_failed++;
        $display("[TB] FAIL ram_addr_%0d: got %h expected %h", a, ram[a], 8'h40 + 8'(a));
      end
    end
    done_load = 1'b1;
    tick();
    done_load = 1'b0;
    tests_run += 3;
    if (byte_count !== 5'd16) begin tests_failed++; $display("[TB] FAIL no_wrap_count: got %0d expected 16", byte_count); end
    if (prog_data !== 8'h40) begin tests_failed++; $display("[TB] FAIL no_wrap_data: got %h expected 40", prog_data); end
    if (programming !== 1'b1) begin tests_failed++; $display("[TB] FAIL no_wrap_prog: got %b expected 1", programming); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tests_run += 2;
    if (programming !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_drop: got %b expected 0", programming); end
    if (load_complete !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_complete: got %b expected 1", load_complete); end
  endtask

  task automatic test_done_to_idle();
    tick();
    tests_run += 2;
    if (load_complete !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_complete_sticky: got %b expected 1", load_complete); end
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_in_ready: got %b expected 0", in_ready); end
    start_load();
    tests_run += 4;
    if (load_complete !== 1'b0) begin tests_failed++; $display("[TB] FAIL reload_complete: got %b expected 0", load_complete); end
    if (byte_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL reload_byte_count: got %0d expected 0", byte_count); end
    if (fill_level !== 5'd0) begin tests_failed++; $display("[TB] FAIL reload_fill_level: got %0d expected 0", fill_level); end
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reload_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_mid_stream();
    push_image(8'h10);
    ram_addr = 0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    run_slot(1);
    run_slot(0);
    tests_run += 2;
    if (byte_count !== 5'd2) begin tests_failed++; $display("[TB] FAIL mid_byte_count: got %0d expected 2", byte_count); end
    if (prog_data !== 8'h12) begin tests_failed++; $display("[TB] FAIL mid_prog_data: got %h expected 12", prog_data); end
    do_reset();
    tests_run += 5;
    if (programming !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_programming: got %b expected 0", programming); end
    if (byte_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL rst_mid_byte_count: got %0d expected 0", byte_count); end
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_in_ready: got %b expected 0", in_ready); end
    if (fill_level !== 5'd0) begin tests_failed++; $display("[TB] FAIL rst_mid_fill_level: got %0d expected 0", fill_level); end
    if (prog_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL rst_mid_prog_data: got %h expected 00", prog_data); end
    tick();
    tests_run += 1;
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_stays_idle: got %b expected 0", in_ready); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic push_cks_image(input logic [7:0] cks);
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
    end
    in_data = cks;
    tick();
    idle_inputs();
  endtask

  task automatic test_checksum();
    do_reset();
    start_load();
    push_cks_image(8'h78);
    tests_run += 2;
    if (cksum_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL cks_good_err: got %b expected 0", cksum_err); end
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL cks_good_in_ready: got %b expected 0", in_ready); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tests_run += 1;
    if (programming !== 1'b1) begin tests_failed++; $display("[TB] FAIL cks_good_stream: got %b expected 1", programming); end
    do_reset();
    start_load();
    push_cks_image(8'h00);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tests_run += 3;
    if (cksum_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL cks_bad_err: got %b expected 1", cksum_err); end
    if (load_complete !== 1'b1) begin tests_failed++; $display("[TB] FAIL cks_bad_complete: got %b expected 1", load_complete); end
    if (programming !== 1'b0) begin tests_failed++; $display("[TB] FAIL cks_bad_programming: got %b expected 0", programming); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    test_reset();
    test_fill_backpressure();
    test_alignment_release();
    test_done_to_idle();
    test_reset_mid_stream();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
